// File: rtl/exa_crosb_pkg.sv
// Shared types and constants for the crossbar output VC allocator.
package exa_crosb_pkg;

  localparam int CREDIT_MODE_PKT  = 0;
  localparam int CREDIT_MODE_FLIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/exa_crosb_rr_arb.sv
// Round-robin arbiter: first request at or after ptr (with wrap) wins, one-hot grant plus index.
module exa_crosb_rr_arb #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int            t;
  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    t       = 0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      t   = (int'(ptr) + k) % N;
      idx = PW'(t);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/exa_crosb_out_vc_alloc.sv
// Per-output VC allocator: strict priority across classes, round-robin within a class,
// packet-granular ownership and counter-based credits per output VC.
module exa_crosb_out_vc_alloc
  import exa_crosb_pkg::*;
#(
  parameter  int INPUT_NUM      = 4,
  parameter  int VC_NUM         = 2,
  parameter  int PRIO_NUM       = 2,
  parameter  int OUT_FIFO_DEPTH = 40,
  parameter  int MAX_PKT_FLITS  = 18,
  parameter  int CREDIT_MODE    = 0,
  localparam int NVC            = VC_NUM * PRIO_NUM,
  localparam int VCW            = (NVC > 1) ? $clog2(NVC) : 1,
  localparam int CW             = $clog2(OUT_FIFO_DEPTH + 1)
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [INPUT_NUM-1:0]     i_req,
  input  logic [INPUT_NUM*VCW-1:0] i_req_vc,
  input  logic                     i_xfer,
  input  logic                     i_xfer_last,
  input  logic [NVC-1:0]           i_credit_ret,
  output logic [INPUT_NUM-1:0]     o_grant,
  output logic [VCW-1:0]           o_grant_vc,
  output logic                     o_flit_ok,
  output logic [NVC*CW-1:0]        o_credits,
  output logic                     o_credit_err,
  output logic                     o_state
);

  typedef logic [VCW-1:0] vc_idx_t;

  localparam int PW  = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
  localparam int PCW = (PRIO_NUM > 1) ? $clog2(PRIO_NUM) : 1;
  localparam logic [CW-1:0] FULL = CW'(OUT_FIFO_DEPTH);
  localparam logic [CW-1:0] THR  = (CREDIT_MODE == CREDIT_MODE_FLIT) ? CW'(1) : CW'(MAX_PKT_FLITS);

  if (MAX_PKT_FLITS > OUT_FIFO_DEPTH) begin : g_cfg_chk
    $error("MAX_PKT_FLITS exceeds OUT_FIFO_DEPTH: a packet could never be granted");
  end

  alloc_state_t                   state_q, state_d;
  logic [INPUT_NUM-1:0]           grant_q, grant_d;
  vc_idx_t                        grant_vc_q, grant_vc_d;
  logic [PRIO_NUM-1:0][PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic                           err_q, err_d;

  vc_idx_t [INPUT_NUM-1:0]        req_vc_a;
  logic [NVC-1:0][CW-1:0]         credits;
  logic [NVC-1:0]                 vc_err;
  logic [PRIO_NUM-1:0][INPUT_NUM-1:0] elig;
  logic [PRIO_NUM-1:0][INPUT_NUM-1:0] cls_gnt;
  logic [PRIO_NUM-1:0][PW-1:0]    cls_idx;
  logic [PRIO_NUM-1:0]            cls_any;
  logic                           win_any;
  logic [INPUT_NUM-1:0]           win_gnt;
  logic [PW-1:0]                  win_idx;
  logic [PCW-1:0]                 win_cls;

  assign req_vc_a = i_req_vc;

  // Out-of-range VC requests are simply never eligible.
  always_comb begin
    elig = '0;
    for (int p = 0; p < PRIO_NUM; p++) begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        if (i_req[i] && (int'(req_vc_a[i]) < NVC) && ((int'(req_vc_a[i]) / VC_NUM) == p) &&
            (credits[req_vc_a[i]] >= THR)) begin
          elig[p][i] = 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < PRIO_NUM; p++) begin : g_arb
    exa_crosb_rr_arb #(.N(INPUT_NUM)) u_arb (
      .req     (elig[p]),
      .ptr     (rr_ptr_q[p]),
      .gnt     (cls_gnt[p]),
      .gnt_idx (cls_idx[p]),
      .any     (cls_any[p])
    );
  end

  // Ascending scan so the highest class with any eligible input overrides lower ones.
  always_comb begin
    win_any = 1'b0;
    win_gnt = '0;
    win_idx = '0;
    win_cls = '0;
    for (int p = 0; p < PRIO_NUM; p++) begin
      if (cls_any[p]) begin
        win_any = 1'b1;
        win_gnt = cls_gnt[p];
        win_idx = cls_idx[p];
        win_cls = PCW'(p);
      end
    end
  end

  // i_xfer is the M_AXIS tvalid & tready beat; i_xfer_last marks that beat as tlast.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_vc_d = grant_vc_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q | (|vc_err) | (i_xfer && (state_q == IDLE));
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d           = BUSY;
          grant_d           = win_gnt;
          grant_vc_d        = req_vc_a[win_idx];
          rr_ptr_d[win_cls] = (win_idx == PW'(INPUT_NUM - 1)) ? '0 : win_idx + PW'(1);
        end
      end
      BUSY: begin
        if (i_xfer && i_xfer_last) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_vc_q <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_vc_q <= grant_vc_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
    end
  end

  for (genvar v = 0; v < NVC; v++) begin : g_credit
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec, inc, cnt_err;

    assign dec = i_xfer && (state_q == BUSY) && (grant_vc_q == VCW'(v));
    assign inc = i_credit_ret[v];

    // A simultaneous send and return cancel out; otherwise clamp and flag.
    always_comb begin
      cnt_d   = cnt_q;
      cnt_err = 1'b0;
      if (dec && !inc) begin
        if (cnt_q == '0) cnt_err = 1'b1;
        else             cnt_d   = cnt_q - CW'(1);
      end else if (inc && !dec) begin
        if (cnt_q == FULL) cnt_err = 1'b1;
        else               cnt_d   = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) cnt_q <= FULL;
      else          cnt_q <= cnt_d;
    end

    assign credits[v] = cnt_q;
    assign vc_err[v]  = cnt_err;
  end

  assign o_grant      = grant_q;
  assign o_grant_vc   = grant_vc_q;
  assign o_flit_ok    = (state_q == BUSY) &&
                        ((CREDIT_MODE == CREDIT_MODE_PKT) || (credits[grant_vc_q] != '0));
  assign o_credits    = credits;
  assign o_credit_err = err_q;
  assign o_state      = (state_q == BUSY);

endmodule
